sequenciador_ciclo: RTL and testbench

- Multi-cycle controller for the single-issue RISC-V datapath: owns the stage state register and drives the per-stage enables for fetch, register file, ALU, memory and PC update.
- Adds run/step modes for board debugging, programmable settle delays after EX and WB, halt on an all-zero instruction, and saturating instruction and cycle counters for the displays.
- Sits between the top level and the datapath modules; its `estado` output replaces the top-level state register.

---
 rtl/riscv_ctrl_pkg.sv | 29 ++
 rtl/contador_sat.sv | 23 ++
 rtl/sequenciador_ciclo.sv | 162 ++++++++++++++++
 tb/tb_sequenciador_ciclo.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared state codes for the multi-cycle RISC-V controller. The datapath
// modules compare the controller's estado output against these constants.
package riscv_ctrl_pkg;

    // Default width of the instruction and cycle counters.
    localparam int CNT_W_DEF = 16;

    // Stage codes; unused encodings are recovered to ST_IDLE by the FSM.
    typedef enum logic [3:0] {
        ST_IF    = 4'b0000,
        ST_ID    = 4'b0001,
        ST_EX    = 4'b0010,
        ST_MEM   = 4'b0011,
        ST_WB    = 4'b0100,
        ST_WEX   = 4'b0101,
        ST_WWB   = 4'b0110,
        ST_SUMPC = 4'b1000,
        ST_FIM   = 4'b1001,
        ST_IDLE  = 4'b1010,
        ST_PAUSE = 4'b1011,
        ST_DISP  = 4'b1100
    } estado_t;

    // A state counts as busy unless the controller is waiting or finished.
    function automatic logic is_busy(input estado_t s);
        return !((s == ST_IDLE) || (s == ST_PAUSE) || (s == ST_FIM));
    endfunction

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter with asynchronous active-low clear. Once all ones
// are reached it holds there until the next clear.
module contador_sat
    import riscv_ctrl_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled cycles, stopping at the maximum value instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sequenciador_ciclo.sv
// Multi-cycle stage sequencer for the single-issue RISC-V datapath.
// Walks IF, ID, EX, MEM, WB, DISP, SUMPC with optional settle states after
// EX and WB, supports step-by-step debugging through PAUSE, halts in FIM on
// an all-zero instruction, and keeps saturating instruction/cycle counters.
// All outputs are registered and depend only on the state register; the
// enables are loaded from the next state so they line up with estado.
// The fim output is high while the controller sits in FIM.
module sequenciador_ciclo
    import riscv_ctrl_pkg::*;
#(
    parameter int EX_WAIT = 2,
    parameter int WB_WAIT = 2,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [31:0]      instrucao,
    output logic [3:0]       estado,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic             disp_en,
    output logic             busy,
    output logic             fim,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    // Reload values for the settle counter: a settle of N cycles loads N-1
    // and leaves the wait state when the counter reads zero.
    localparam logic [3:0] EX_LOAD = (EX_WAIT > 0) ? 4'(EX_WAIT - 1) : 4'd0;
    localparam logic [3:0] WB_LOAD = (WB_WAIT > 0) ? 4'(WB_WAIT - 1) : 4'd0;

    estado_t    state_q;
    estado_t    state_d;
    logic [3:0] wait_q;
    logic [3:0] wait_d;
    logic       halt_q;
    logic       halt_d;

    assign estado = state_q;

    // Next-state, settle counter and halt flag selection.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        halt_d  = halt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_IF;
            end
            ST_IF: begin
                state_d = ST_ID;
            end
            ST_ID: begin
                if (instrucao == 32'd0) begin
                    state_d = ST_DISP;
                    halt_d  = 1'b1;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                if (EX_WAIT > 0) begin
                    state_d = ST_WEX;
                    wait_d  = EX_LOAD;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WEX: begin
                if (wait_q == 4'd0) state_d = ST_MEM;
                else                wait_d  = wait_q - 4'd1;
            end
            ST_MEM: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                if (WB_WAIT > 0) begin
                    state_d = ST_WWB;
                    wait_d  = WB_LOAD;
                end else begin
                    state_d = ST_DISP;
                end
            end
            ST_WWB: begin
                if (wait_q == 4'd0) state_d = ST_DISP;
                else                wait_d  = wait_q - 4'd1;
            end
            ST_DISP: begin
                // The halt path skips SUMPC so the PC is left untouched.
                state_d = halt_q ? ST_FIM : ST_SUMPC;
            end
            ST_SUMPC: begin
                state_d = step_mode ? ST_PAUSE : ST_IF;
            end
            ST_PAUSE: begin
                if (step) state_d = ST_IF;
            end
            ST_FIM: begin
                state_d = ST_FIM;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register plus stage enables registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wait_q  <= 4'd0;
            halt_q  <= 1'b0;
            if_en   <= 1'b0;
            id_en   <= 1'b0;
            ex_en   <= 1'b0;
            mem_en  <= 1'b0;
            wb_en   <= 1'b0;
            pc_en   <= 1'b0;
            disp_en <= 1'b0;
            busy    <= 1'b0;
            fim     <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            halt_q  <= halt_d;
            if_en   <= (state_d == ST_IF);
            id_en   <= (state_d == ST_ID);
            ex_en   <= (state_d == ST_EX);
            mem_en  <= (state_d == ST_MEM);
            wb_en   <= (state_d == ST_WB);
            pc_en   <= (state_d == ST_SUMPC);
            disp_en <= (state_d == ST_DISP);
            busy    <= is_busy(state_d);
            fim     <= (state_d == ST_FIM);
        end
    end

    // One retired instruction per cycle spent in SUMPC.
    contador_sat #(.W(CNT_W)) u_instr_count (
        .clk   (clk),
        .rst   (rst),
        .en    (pc_en),
        .count (instr_count)
    );

    // One count per busy cycle.
    contador_sat #(.W(CNT_W)) u_cycle_count (
        .clk   (clk),
        .rst   (rst),
        .en    (busy),
        .count (cycle_count)
    );

endmodule

// File: tb/tb_sequenciador_ciclo.sv
// Bench for sequenciador_ciclo: three instances with different settle and
// counter widths share one stimulus stream; a phase-position reference model
// predicts every output each cycle, plus directed checks for the key cases.
module tb_sequenciador_ciclo;

    logic        clk;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [31:0] instrucao = 32'h00500093;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Per-instance observation
    logic [3:0]  est0, est1, est2;
    logic        if_e[3], id_e[3], ex_e[3], mem_e[3], wb_e[3], pc_e[3];
    logic        disp_e[3], busy_e[3], fim_e[3];
    logic [15:0] ic0, cc0;
    logic [3:0]  ic1, cc1, ic2, cc2;

    logic [3:0]  obs_est[3];
    logic [8:0]  obs_en[3];
    logic [15:0] obs_ic[3];
    logic [15:0] obs_cc[3];

    // Model parameters per instance
    int pe[3]   = '{2, 0, 3};
    int pw[3]   = '{2, 0, 1};
    int pmax[3] = '{65535, 15, 15};

    // Model state: 0 idle, 1 running (pos = cycle index since IF),
    // 2 paused, 3 halt display, 4 finished
    int m_mode[3] = '{0, 0, 0};
    int m_pos[3]  = '{0, 0, 0};
    int m_ic[3]   = '{0, 0, 0};
    int m_cc[3]   = '{0, 0, 0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sequenciador_ciclo #(.EX_WAIT(2), .WB_WAIT(2), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
        .instrucao(instrucao), .estado(est0), .if_en(if_e[0]), .id_en(id_e[0]),
        .ex_en(ex_e[0]), .mem_en(mem_e[0]), .wb_en(wb_e[0]), .pc_en(pc_e[0]),
        .disp_en(disp_e[0]), .busy(busy_e[0]), .fim(fim_e[0]),
        .instr_count(ic0), .cycle_count(cc0)
    );

    sequenciador_ciclo #(.EX_WAIT(0), .WB_WAIT(0), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
        .instrucao(instrucao), .estado(est1), .if_en(if_e[1]), .id_en(id_e[1]),
        .ex_en(ex_e[1]), .mem_en(mem_e[1]), .wb_en(wb_e[1]), .pc_en(pc_e[1]),
        .disp_en(disp_e[1]), .busy(busy_e[1]), .fim(fim_e[1]),
        .instr_count(ic1), .cycle_count(cc1)
    );

    sequenciador_ciclo #(.EX_WAIT(3), .WB_WAIT(1), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
        .instrucao(instrucao), .estado(est2), .if_en(if_e[2]), .id_en(id_e[2]),
        .ex_en(ex_e[2]), .mem_en(mem_e[2]), .wb_en(wb_e[2]), .pc_en(pc_e[2]),
        .disp_en(disp_e[2]), .busy(busy_e[2]), .fim(fim_e[2]),
        .instr_count(ic2), .cycle_count(cc2)
    );

    assign obs_est[0] = est0;
    assign obs_est[1] = est1;
    assign obs_est[2] = est2;
    assign obs_ic[0]  = ic0;
    assign obs_ic[1]  = {12'd0, ic1};
    assign obs_ic[2]  = {12'd0, ic2};
    assign obs_cc[0]  = cc0;
    assign obs_cc[1]  = {12'd0, cc1};
    assign obs_cc[2]  = {12'd0, cc2};

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            obs_en[k] = {if_e[k], id_e[k], ex_e[k], mem_e[k], wb_e[k], pc_e[k],
                         disp_e[k], busy_e[k], fim_e[k]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected state code from the model's mode and position in the instruction.
    function automatic logic [3:0] exp_code(input int mode, input int pos, input int e, input int w);
        case (mode)
            0: return 4'hA;
            2: return 4'hB;
            3: return 4'hC;
            4: return 4'h9;
            default: begin
                if (pos <= 2)         return 4'(pos);
                if (pos <= 2 + e)     return 4'h5;
                if (pos == 3 + e)     return 4'h3;
                if (pos == 4 + e)     return 4'h4;
                if (pos <= 4 + e + w) return 4'h6;
                if (pos == 5 + e + w) return 4'hC;
                return 4'h8;
            end
        endcase
    endfunction

    // {if, id, ex, mem, wb, pc, disp, busy, fim}
    function automatic logic [8:0] exp_en(input logic [3:0] c);
        return {c == 4'h0, c == 4'h1, c == 4'h2, c == 4'h3, c == 4'h4, c == 4'h8,
                c == 4'hC, !(c == 4'hA || c == 4'hB || c == 4'h9), c == 4'h9};
    endfunction

    // Reference model update
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                m_mode[k] = 0; m_pos[k] = 0; m_ic[k] = 0; m_cc[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                logic [3:0] c;
                logic [8:0] en;
                c = exp_code(m_mode[k], m_pos[k], pe[k], pw[k]);
                en = exp_en(c);
                if (en[1] && m_cc[k] < pmax[k]) m_cc[k]++;
                if (c == 4'h8 && m_ic[k] < pmax[k]) m_ic[k]++;
                case (m_mode[k])
                    0: if (start) begin m_mode[k] = 1; m_pos[k] = 0; end
                    1: begin
                        if (m_pos[k] == 1 && instrucao == 32'd0) m_mode[k] = 3;
                        else if (m_pos[k] == 6 + pe[k] + pw[k]) begin
                            m_pos[k] = 0;
                            if (step_mode) m_mode[k] = 2;
                        end else m_pos[k]++;
                    end
                    2: if (step) begin m_mode[k] = 1; m_pos[k] = 0; end
                    3: m_mode[k] = 4;
                    default: m_mode[k] = 4;
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                logic [3:0] c;
                c = exp_code(m_mode[k], m_pos[k], pe[k], pw[k]);
                check($sformatf("estado%0d", k), 32'(obs_est[k]), 32'(c));
                check($sformatf("enables%0d", k), 32'(obs_en[k]), 32'(exp_en(c)));
                check($sformatf("instr_count%0d", k), 32'(obs_ic[k]), 32'(m_ic[k]));
                check($sformatf("cycle_count%0d", k), 32'(obs_cc[k]), 32'(m_cc[k]));
            end
        end
    end

    task automatic wait_est(input int k, input logic [3:0] code, input int maxc, input string tag);
        int n = 0;
        while (obs_est[k] !== code && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reached"}, 32'(obs_est[k] === code), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  seq[13];
        logic [15:0] saved;
        int n;
        seq = '{4'hA, 4'h0, 4'h1, 4'h2, 4'h5, 4'h5, 4'h3, 4'h4, 4'h6, 4'h6, 4'hC, 4'h8, 4'h0};

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_estado%0d", k), 32'(obs_est[k]), 32'hA);
            check($sformatf("rst_enables%0d", k), 32'(obs_en[k]), 32'h0);
            check($sformatf("rst_counts%0d", k), {obs_ic[k], obs_cc[k]}, 32'h0);
        end
        chk_en = 1'b1;
        rst = 1'b1;
        @(negedge clk);

        // Reset and run: literal stage sequence of the default instance
        start = 1'b1;
        for (int i = 0; i < 13; i++) begin
            check($sformatf("seq_%0d", i), 32'(obs_est[0]), 32'(seq[i]));
            @(negedge clk);
        end
        check("run_instr_count", 32'(obs_ic[0]), 32'd1);

        // Step mode: park in PAUSE for 20 cycles, then release with one pulse
        step_mode = 1'b1;
        wait_est(0, 4'hB, 40, "pause");
        saved = obs_cc[0];
        repeat (20) begin
            check("pause_hold", 32'(obs_est[0]), 32'hB);
            check("pause_busy", 32'(obs_en[0][1]), 32'd0);
            check("pause_cycles", 32'(obs_cc[0]), 32'(saved));
            @(negedge clk);
        end
        step = 1'b1;
        step_mode = 1'b0;
        @(negedge clk);
        step = 1'b0;
        check("step_release", 32'(obs_est[0]), 32'h0);

        // No settle states: IF to next IF in 7 cycles
        wait_est(1, 4'h0, 20, "zw_if");
        @(negedge clk);
        n = 1;
        while (obs_est[1] !== 4'h0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("zw_latency", 32'(n), 32'd7);

        // EX_WAIT=3: exactly three consecutive WEX cycles
        wait_est(2, 4'h2, 30, "ew_ex");
        @(negedge clk);
        n = 0;
        while (obs_est[2] === 4'h5 && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("ew_wex_cycles", 32'(n), 32'd3);

        // Randomized instructions, step_mode and step pulses
        repeat (80) begin
            @(negedge clk);
            instrucao = $urandom | 32'd1;
            step_mode = ($urandom_range(0, 7) == 0);
            step = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        step_mode = 1'b0;
        step = 1'b0;
        instrucao = 32'h00500093;
        repeat (3) begin
            @(negedge clk);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
        end

        // Async reset between clock edges while in WEX
        wait_est(0, 4'h2, 40, "ar_ex");
        @(posedge clk);
        #2;
        check("ar_pre_wex", 32'(obs_est[0]), 32'h5);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ar_estado%0d", k), 32'(obs_est[k]), 32'hA);
            check($sformatf("ar_enables%0d", k), 32'(obs_en[k]), 32'h0);
            check($sformatf("ar_counts%0d", k), {obs_ic[k], obs_cc[k]}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Saturation of the 4-bit counters
        repeat (300) @(negedge clk);
        check("sat_instr1", 32'(obs_ic[1]), 32'd15);
        check("sat_cycle1", 32'(obs_cc[1]), 32'd15);
        check("sat_instr2", 32'(obs_ic[2]), 32'd15);
        check("sat_cycle2", 32'(obs_cc[2]), 32'd15);

        // Halt on an all-zero instruction
        wait_est(0, 4'h0, 20, "halt_if");
        saved = obs_ic[0];
        instrucao = 32'd0;
        @(negedge clk);
        check("halt_id", 32'(obs_est[0]), 32'h1);
        @(negedge clk);
        check("halt_disp", 32'(obs_est[0]), 32'hC);
        check("halt_disp_pc", 32'(obs_en[0][3]), 32'd0);
        @(negedge clk);
        repeat (10) begin
            check("halt_fim", 32'(obs_est[0]), 32'h9);
            check("halt_final", 32'(obs_en[0][0]), 32'd1);
            check("halt_pc_en", 32'(obs_en[0][3]), 32'd0);
            check("halt_instr", 32'(obs_ic[0]), 32'(saved));
            start = $urandom_range(0, 1);
            step = $urandom_range(0, 1);
            @(negedge clk);
        end
        step = 1'b0;

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
